ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised instruction-cycle controller for the basic-computer datapath: a one-hot timing sequencer, a registered opcode decoder, the I (indirect) flip-flop and the interrupt machinery (R flip-flop, IEN) in one block. It drives fetch, decode, indirect, execute and interrupt-cycle strobes to the register/bus datapath. Unlike the fixed 16-bit control unit, opcode width and sequence length are parameters. Instruction length is variable: memory-reference execution ends on a datapath handshake, with timeout protection. It also supports halt/restart and interrupts.

## Interface
- WORD_W, 16, instruction word width (≥ 12)
- OP_W, 3, opcode width; decoded output is 2**OP_W one-hot lines
- T_STEPS, 16, number of timing states T0..T(T_STEPS-1) (≥ 5)
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ir_data  in  WORD_W  current IR contents; I = ir_data[WORD_W-1], opcode = ir_data[WORD_W-2 -: OP_W]
- exec_done  in  1  datapath ends memory-reference execute
- irq  in  1  level interrupt request (FGI|FGO)
- start  in  1  restart after halt
- t_out  out  T_STEPS  one-hot timing signals
- d_out  out  2**OP_W  registered one-hot opcode decode
- i_out, r_out, ien_out  out  1 each  I, R, IEN flip-flops
- running  out  1  S flip-flop
- ar_from_pc, ir_load, pc_inr, ar_from_ir, ar_indirect  out  1 each  fetch/decode/indirect strobes
- int_save, int_store, int_done  out  1 each  interrupt-cycle strobes
- rr_exec, io_exec, mem_exec  out  1 each  execute-class strobes
- timeout_err  out  1  sticky sequencer timeout

## Operation
- DR = d_out[2**OP_W-1] (register-ref/IO class); MR = !DR.
- Normal cycle (R=0, running=1):
  - T0: ar_from_pc.
  - T1: ir_load, pc_inr.
  - T2: ar_from_ir; at this edge d_out and i_out load from ir_data.
  - T3: MR&I → ar_indirect; MR&!I → no strobe; DR&!I → rr_exec; DR&I → io_exec.
  - T≥4 with MR: mem_exec.
- Interrupt cycle (R=1):
  - T0: int_save.
  - T1: int_store.
  - T2: int_done. At this edge IEN←0, R←0 and SC←T0.
  - No fetch strobes are asserted while R=1.
- R set: at an edge where running & ien_out & irq and the current state is not T0/T1/T2.
- IO control, at the io_exec edge:
  - ir_data[7] (ION) → IEN←1.
  - ir_data[6] (IOF) → IEN←0.
  - Both set → IEN←0.
- Halt, at the rr_exec edge: ir_data[0] (HLT) → running←0 and SC←T0.
  - While halted: SC holds T0, all strobes are 0, R is not set.
  - start=1 sets running←1; fetch begins at T0 on the next cycle.
- SC clear and next-state priority:
  1. rst_n low.
  2. HLT.
  3. int_done.
  4. DR at T3.
  5. exec_done while MR & T≥4.
  6. Timeout.
  7. Increment.
- exec_done in any other state is ignored.
- Timeout: MR at T(T_STEPS-1) without exec_done → SC←T0 and timeout_err←1, held until reset. The next fetch proceeds normally.
- Strobes are combinational from the registered SC, R, D, I and running state. Exactly one t_out bit is high at all times.

## Timing
- Reset (asynchronous, takes effect immediately) values:
  - t_out=1 (T0), d_out=0, i_out=0, r_out=0, ien_out=0.
  - running=1, timeout_err=0.
  - All strobes: ar_from_pc=1, because of R'T0; all others 0.
- Release of rst_n: first rising edge advances T0→T1.
- Decode latency: ir_data sampled at the T2→T3 edge. d_out/i_out are valid throughout T3 onward and stable until the next T2 edge.
- Minimum instruction: DR, 4 cycles (T0–T3). Minimum memory-reference instruction: 5 cycles, with exec_done high in T4.
- R set on the same edge that clears SC: the next cycle is RT0 and no fetch occurs.
- irq asserted during T0–T2 is not sampled until T3.
- The interrupt cycle is 3 cycles.
- Counter never exceeds T(T_STEPS-1); wrap-around occurs only through the timeout path.

## Test plan
- Reset mid-T5 → t_out=1, d_out=0, r_out=0, ien_out=0, running=1 immediately; ar_from_pc=1.
- Memory-reference opcode 3'b010, I=1, exec_done pulsed in T6 → ar_indirect in T3, mem_exec in T4–T6, t_out returns to 1 after 7 cycles, d_out=8'b0000_0100.
- DR with ir_data=16'h7001 (HLT) → rr_exec in T3, running=0, SC stuck at T0 for 10 cycles; start pulse → T1 on the following edge.
- ION (16'hF080), then irq=1 held during a memory-reference instruction → R set at T3 edge, int_save/int_store/int_done in the next cycles after the instruction ends, ien_out=0 and r_out=0 after int_done.
- T_STEPS=8, memory-reference instruction with no exec_done → SC wraps from T7 to T0, timeout_err=1 and stays 1 through subsequent normal instructions.
- OP_W=4, WORD_W=20, opcode 4'hF with I=0 → d_out[15]=1, rr_exec in T3, instruction length 4 cycles.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: datapath-facing inputs, strobes and status of the instruction-cycle controller
interface ctrl_sequencer_if #(
    parameter int WORD_W  = 16,
    parameter int OP_W    = 3,
    parameter int T_STEPS = 16
);
    logic [WORD_W-1:0]    ir_data;
    logic                 exec_done;
    logic                 irq;
    logic                 start;
    logic [T_STEPS-1:0]   t_out;
    logic [2**OP_W-1:0]   d_out;
    logic                 i_out;
    logic                 r_out;
    logic                 ien_out;
    logic                 running;
    logic                 ar_from_pc;
    logic                 ir_load;
    logic                 pc_inr;
    logic                 ar_from_ir;
    logic                 ar_indirect;
    logic                 int_save;
    logic                 int_store;
    logic                 int_done;
    logic                 rr_exec;
    logic                 io_exec;
    logic                 mem_exec;
    logic                 timeout_err;

    modport master (
        input  ir_data, exec_done, irq, start,
        output t_out, d_out, i_out, r_out, ien_out, running,
               ar_from_pc, ir_load, pc_inr, ar_from_ir, ar_indirect,
               int_save, int_store, int_done, rr_exec, io_exec, mem_exec, timeout_err
    );

    modport slave (
        output ir_data, exec_done, irq, start,
        input  t_out, d_out, i_out, r_out, ien_out, running,
               ar_from_pc, ir_load, pc_inr, ar_from_ir, ar_indirect,
               int_save, int_store, int_done, rr_exec, io_exec, mem_exec, timeout_err
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: one-hot timing sequencer, opcode decoder, I/R/IEN flip-flops, halt and timeout
module ctrl_sequencer #(
    parameter int WORD_W  = 16,
    parameter int OP_W    = 3,
    parameter int T_STEPS = 16
) (
    input logic              clk,
    input logic              rst_n,
    ctrl_sequencer_if.master bus
);
    localparam int NOP = 2 ** OP_W;

    logic [T_STEPS-1:0] sc;
    logic [NOP-1:0]     d;
    logic               i, r, ien, running, timeout_err;
    logic               fetch, dr, mr, t4_up, t_last, hlt, irq_take, io_ctl, unused_ok;

    // fetch/decode strobes only in a running normal cycle; execute strobes may overlap a pending R
    assign fetch    = running & ~r;
    assign dr       = d[NOP-1];
    assign mr       = ~dr;
    assign t4_up    = |sc[T_STEPS-1:4];
    assign t_last   = sc[T_STEPS-1];
    assign hlt      = bus.rr_exec & bus.ir_data[0];
    assign io_ctl   = bus.io_exec & (bus.ir_data[7] | bus.ir_data[6]);
    assign irq_take = running & ien & bus.irq & ~(sc[0] | sc[1] | sc[2]);
    assign unused_ok = ^bus.ir_data;

    assign bus.t_out       = sc;
    assign bus.d_out       = d;
    assign bus.i_out       = i;
    assign bus.r_out       = r;
    assign bus.ien_out     = ien;
    assign bus.running     = running;
    assign bus.timeout_err = timeout_err;
    assign bus.ar_from_pc  = fetch & sc[0];
    assign bus.ir_load     = fetch & sc[1];
    assign bus.pc_inr      = fetch & sc[1];
    assign bus.ar_from_ir  = fetch & sc[2];
    assign bus.ar_indirect = running & sc[3] & mr & i;
    assign bus.rr_exec     = running & sc[3] & dr & ~i;
    assign bus.io_exec     = running & sc[3] & dr & i;
    assign bus.mem_exec    = running & t4_up & mr;
    assign bus.int_save    = running & r & sc[0];
    assign bus.int_store   = running & r & sc[1];
    assign bus.int_done    = running & r & sc[2];

    // sequencer state: SC clear sources in priority order, then increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc          <= T_STEPS'(1);
            d           <= '0;
            i           <= 1'b0;
            r           <= 1'b0;
            ien         <= 1'b0;
            running     <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            if (!running && bus.start) running <= 1'b1;
            if (bus.ar_from_ir) begin
                d <= NOP'(1) << bus.ir_data[WORD_W-2 -: OP_W];
                i <= bus.ir_data[WORD_W-1];
            end
            if (irq_take) r <= 1'b1;
            if (io_ctl) ien <= bus.ir_data[7] & ~bus.ir_data[6];
            if (hlt) begin
                running <= 1'b0;
                sc      <= T_STEPS'(1);
            end else if (bus.int_done) begin
                sc  <= T_STEPS'(1);
                r   <= 1'b0;
                ien <= 1'b0;
            end else if (running && dr && sc[3]) begin
                sc <= T_STEPS'(1);
            end else if (running && mr && t4_up && bus.exec_done) begin
                sc <= T_STEPS'(1);
            end else if (running && mr && t_last) begin
                sc          <= T_STEPS'(1);
                timeout_err <= 1'b1;
            end else if (running) begin
                sc <= {sc[T_STEPS-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed checks of default, short-sequence and wide-opcode controllers
module tb_ctrl_sequencer;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ctrl_sequencer_if b0 ();
    ctrl_sequencer_if #(.T_STEPS(8)) b1 ();
    ctrl_sequencer_if #(.WORD_W(20), .OP_W(4)) b2 ();

    ctrl_sequencer u0 (.clk(clk), .rst_n(rst0), .bus(b0));
    ctrl_sequencer #(.T_STEPS(8)) u1 (.clk(clk), .rst_n(rst1), .bus(b1));
    ctrl_sequencer #(.WORD_W(20), .OP_W(4)) u2 (.clk(clk), .rst_n(rst2), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        b0.ir_data = '0; b0.exec_done = 1'b0; b0.irq = 1'b0; b0.start = 1'b0;
        b1.ir_data = '0; b1.exec_done = 1'b0; b1.irq = 1'b0; b1.start = 1'b0;
        b2.ir_data = '0; b2.exec_done = 1'b0; b2.irq = 1'b0; b2.start = 1'b0;
        tick(2);
        chk("rst_t", b0.t_out, 1);
        chk("rst_d", b0.d_out, 0);
        chk("rst_r", b0.r_out, 0);
        chk("rst_ien", b0.ien_out, 0);
        chk("rst_run", b0.running, 1);
        chk("rst_to", b0.timeout_err, 0);
        chk("rst_pc", b0.ar_from_pc, 1);
        chk("rst_ld", b0.ir_load, 0);
        rst0 = 1'b1;
        tick(1);
        chk("t1_t", b0.t_out, 2);
        chk("t1_ld", b0.ir_load, 1);
        chk("t1_inr", b0.pc_inr, 1);
        chk("t1_pc", b0.ar_from_pc, 0);
        b0.ir_data = 16'hA123;
        tick(1);
        chk("t2_t", b0.t_out, 4);
        chk("t2_ir", b0.ar_from_ir, 1);
        tick(1);
        chk("mr_t3", b0.t_out, 8);
        chk("mr_d", b0.d_out, 8'h04);
        chk("mr_i", b0.i_out, 1);
        chk("mr_ind", b0.ar_indirect, 1);
        chk("mr_t3mex", b0.mem_exec, 0);
        tick(1);
        chk("mr_t4", b0.t_out, 16);
        chk("mr_t4mex", b0.mem_exec, 1);
        tick(2);
        chk("mr_t6", b0.t_out, 64);
        chk("mr_t6mex", b0.mem_exec, 1);
        b0.exec_done = 1'b1;
        tick(1);
        b0.exec_done = 1'b0;
        chk("mr_end", b0.t_out, 1);
        chk("mr_endpc", b0.ar_from_pc, 1);
        chk("mr_dhold", b0.d_out, 8'h04);
        tick(5);
        chk("mid_t5", b0.t_out, 32);
        rst0 = 1'b0;
        #1;
        chk("arst_t", b0.t_out, 1);
        chk("arst_d", b0.d_out, 0);
        chk("arst_i", b0.i_out, 0);
        chk("arst_run", b0.running, 1);
        chk("arst_pc", b0.ar_from_pc, 1);
        rst0 = 1'b1;
        b0.ir_data = 16'h7001;
        tick(3);
        chk("hlt_t3", b0.t_out, 8);
        chk("hlt_rr", b0.rr_exec, 1);
        chk("hlt_d", b0.d_out, 8'h80);
        tick(1);
        chk("hlt_run", b0.running, 0);
        chk("hlt_t", b0.t_out, 1);
        chk("hlt_pc", b0.ar_from_pc, 0);
        tick(10);
        chk("hlt_stuck", b0.t_out, 1);
        chk("hlt_run2", b0.running, 0);
        b0.start = 1'b1;
        tick(1);
        b0.start = 1'b0;
        chk("st_run", b0.running, 1);
        chk("st_t", b0.t_out, 1);
        chk("st_pc", b0.ar_from_pc, 1);
        tick(1);
        chk("st_t1", b0.t_out, 2);
        b0.ir_data = 16'hF080;
        tick(2);
        chk("ion_t3", b0.t_out, 8);
        chk("ion_io", b0.io_exec, 1);
        chk("ion_rr", b0.rr_exec, 0);
        b0.irq = 1'b1;
        tick(1);
        chk("ion_t", b0.t_out, 1);
        chk("ion_ien", b0.ien_out, 1);
        chk("ion_r", b0.r_out, 0);
        b0.ir_data = 16'h2000;
        tick(3);
        chk("irq_t3", b0.t_out, 8);
        chk("irq_r3", b0.r_out, 0);
        chk("irq_ind", b0.ar_indirect, 0);
        chk("irq_i", b0.i_out, 0);
        tick(1);
        chk("irq_r4", b0.r_out, 1);
        chk("irq_mex", b0.mem_exec, 1);
        b0.exec_done = 1'b1;
        tick(1);
        b0.exec_done = 1'b0;
        b0.irq = 1'b0;
        chk("int_t0", b0.t_out, 1);
        chk("int_save", b0.int_save, 1);
        chk("int_nopc", b0.ar_from_pc, 0);
        tick(1);
        chk("int_store", b0.int_store, 1);
        chk("int_nold", b0.ir_load, 0);
        tick(1);
        chk("int_done", b0.int_done, 1);
        chk("int_noir", b0.ar_from_ir, 0);
        tick(1);
        chk("int_r", b0.r_out, 0);
        chk("int_ien", b0.ien_out, 0);
        chk("int_t", b0.t_out, 1);
        chk("int_pc", b0.ar_from_pc, 1);
        rst0 = 1'b0;
        rst1 = 1'b1;
        tick(7);
        chk("to_t7", b1.t_out, 8'h80);
        chk("to_pre", b1.timeout_err, 0);
        chk("to_mex", b1.mem_exec, 1);
        tick(1);
        chk("to_wrap", b1.t_out, 1);
        chk("to_err", b1.timeout_err, 1);
        b1.ir_data = 16'h7000;
        tick(3);
        chk("to_rr", b1.rr_exec, 1);
        tick(1);
        chk("to_t0", b1.t_out, 1);
        chk("to_sticky", b1.timeout_err, 1);
        chk("to_run", b1.running, 1);
        rst1 = 1'b0;
        rst2 = 1'b1;
        b2.ir_data = 20'h78000;
        tick(3);
        chk("w_t3", b2.t_out, 8);
        chk("w_d", b2.d_out, 16'h8000);
        chk("w_rr", b2.rr_exec, 1);
        chk("w_i", b2.i_out, 0);
        tick(1);
        chk("w_t0", b2.t_out, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
